// File: rtl/k_alu_pkg.sv
`default_nettype none
// ============================================================================
// k_alu_pkg : opcode map, FSM states and flag indices for k_alu_seq
// Revision  : 1.0
// ============================================================================
package k_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLT   = 4'd2;
  localparam logic [3:0] OP_SGT   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOTA  = 4'd7;
  localparam logic [3:0] OP_NOR   = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;
  localparam logic [3:0] OP_SLL   = 4'd10;
  localparam logic [3:0] OP_SRL   = 4'd11;
  localparam logic [3:0] OP_SRA   = 4'd12;
  localparam logic [3:0] OP_INC4  = 4'd13;
  localparam logic [3:0] OP_DEC4  = 4'd14;
  localparam logic [3:0] OP_HAM   = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Ops whose C/V flags come from the shared adder.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC4) || (op == OP_DEC4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/k_alu_iter.sv
`default_nettype none
// ============================================================================
// k_alu_iter : iterative shifter (1 bit/cycle) and popcount (HAM_BITS/cycle)
// Revision   : 1.0
// ============================================================================
module k_alu_iter
  import k_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int HAM_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [3:0]                 op_i,
  input  logic [WIDTH-1:0]           operand_i,
  input  logic [$clog2(WIDTH)-1:0]   shamt_i,
  output logic                       done_o,
  output logic [WIDTH-1:0]           result_o
);

  localparam int CW        = $clog2(WIDTH + 1);
  localparam int HAM_STEPS = WIDTH / HAM_BITS;

  logic [3:0]       op_q,  op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] step;
  logic [CW-1:0]    chunk_pop;
  logic [CW-1:0]    sum_next;

  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < HAM_BITS; i++) begin
      chunk_pop = chunk_pop + CW'(acc_q[i]);
    end
  end

  always_comb begin
    step = acc_q >> HAM_BITS;
    case (op_q)
      OP_SLL:  step = acc_q << 1;
      OP_SRL:  step = acc_q >> 1;
      OP_SRA:  step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: step = acc_q >> HAM_BITS;
    endcase
  end

  assign sum_next = sum_q + chunk_pop;

  // Result is presented combinationally on the final step so the caller can
  // register it at the same edge the counter expires.
  assign done_o   = (cnt_q == CW'(1));
  assign result_o = (op_q == OP_HAM) ? {{(WIDTH-CW){1'b0}}, sum_next} : step;

  always_comb begin
    op_d  = op_q;
    acc_d = acc_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (start_i) begin
      op_d  = op_i;
      acc_d = operand_i;
      sum_d = '0;
      cnt_d = (op_i == OP_HAM) ? CW'(HAM_STEPS) : CW'(shamt_i);
    end else if (cnt_q != '0) begin
      acc_d = step;
      sum_d = sum_next;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      acc_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/k_alu_seq.sv
`default_nettype none
// ============================================================================
// k_alu_seq : handshaked sequential ALU with registered result and flags.
//             Define K_ALU_SEQ_FLAGS_EN to build the {N,Z,C,V} flag logic.
// Revision  : 1.0
// ============================================================================
module k_alu_seq
  import k_alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int HAM_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             accept;
  logic             multi;
  logic             load;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] iter_operand;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] res_d, res_q;

  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign multi     = (is_shift(sel) && (shamt != '0)) || (sel == OP_HAM);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;

  // One adder serves add, sub, a+4 and a-4; subtraction is a + ~x + 1.
  always_comb begin
    op2 = b;
    cin = 1'b0;
    case (sel)
      OP_SUB:  begin op2 = ~b;             cin = 1'b1; end
      OP_INC4: begin op2 = WIDTH'(4);                  end
      OP_DEC4: begin op2 = ~(WIDTH'(4));   cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_res = '0;
    case (sel)
      OP_ADD, OP_SUB, OP_INC4, OP_DEC4: alu_res = sum[WIDTH-1:0];
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SGT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOTA:  alu_res = ~a;
      OP_NOR:   alu_res = ~(a | b);
      OP_PASSB: alu_res = b;
      // Only reached with a zero shift amount; non-zero shifts go iterative.
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default:  alu_res = '0;
    endcase
  end

  assign iter_operand = (sel == OP_HAM) ? (a ^ b) : a;

  k_alu_iter #(
    .WIDTH    (WIDTH),
    .HAM_BITS (HAM_BITS)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && multi),
    .op_i      (sel),
    .operand_i (iter_operand),
    .shamt_i   (shamt),
    .done_o    (iter_done),
    .result_o  (iter_res)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_d   = alu_res;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = multi ? S_BUSY : S_DONE;
          load    = !multi;
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (iter_done) begin
          state_d = S_DONE;
          load    = 1'b1;
          res_d   = iter_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        res_q <= res_d;
      end
    end
  end

`ifdef K_ALU_SEQ_FLAGS_EN
  logic [3:0] flags_d, flags_q;
  logic       arith_c;
  logic       arith_v;

  assign arith_c = is_arith(sel) && sum[WIDTH];
  assign arith_v = is_arith(sel) && (a[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // C/V only come from the adder path; iterative results never set them.
  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_N] = res_d[WIDTH-1];
    flags_d[FLAG_Z] = (res_d == '0);
    if (state_q != S_BUSY) begin
      flags_d[FLAG_C] = arith_c;
      flags_d[FLAG_V] = arith_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (load) begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  logic unused_carry;
  assign unused_carry = sum[WIDTH];
  assign flags        = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_k_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_k_alu_seq : scoreboard bench for k_alu_seq with a behavioural model
// Revision     : 1.0
// ============================================================================
module tb_k_alu_seq;

  localparam int WIDTH    = 32;
  localparam int HAM_BITS = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
`ifdef K_ALU_SEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_rdy = 1'b0;
  bit seen = 1'b0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  k_alu_seq #(.WIDTH(WIDTH), .HAM_BITS(HAM_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: results, flags and latency straight from the opcode definitions.
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, t;
    logic   c;
    logic   ar;
    int     sh;
    logic [3:0] full;
    sx = $signed(x);
    sy = $signed(y);
    t  = 0;
    c  = 1'b0;
    ar = 1'b0;
    sh = int'(y[4:0]);
    e.lat = 1;
    e.acc = 0;
    e.r   = '0;
    case (s)
      4'd0:  begin e.r = x + y; c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF; t = sx + sy; ar = 1'b1; end
      4'd1:  begin e.r = x - y; c = (x >= y); t = sx - sy; ar = 1'b1; end
      4'd2:  e.r = (sx < sy) ? 32'd1 : 32'd0;
      4'd3:  e.r = (sx > sy) ? 32'd1 : 32'd0;
      4'd4:  e.r = x & y;
      4'd5:  e.r = x | y;
      4'd6:  e.r = x ^ y;
      4'd7:  e.r = ~x;
      4'd8:  e.r = ~(x | y);
      4'd9:  e.r = y;
      4'd10: begin e.r = x << sh; e.lat = sh + 1; end
      4'd11: begin e.r = x >> sh; e.lat = sh + 1; end
      4'd12: begin e.r = 32'($signed(x) >>> sh); e.lat = sh + 1; end
      4'd13: begin e.r = x + 32'd4; c = ({32'd0, x} + 64'd4) > 64'hFFFF_FFFF; t = sx + 4; ar = 1'b1; end
      4'd14: begin e.r = x - 32'd4; c = (x >= 32'd4); t = sx - 4; ar = 1'b1; end
      default: begin e.r = 32'($countones(x ^ y)); e.lat = WIDTH / HAM_BITS + 1; end
    endcase
    full = {e.r[31], (e.r == 32'd0), c, ar && ((t > SMAX) || (t < SMIN))};
    e.f  = FLAGS_ON ? full : 4'b0000;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
        end
        chk("res", {32'd0, res}, {32'd0, q[0].r});
        chk("flags", {60'd0, flags}, {60'd0, q[0].f});
        if (out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    int   n;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    sel = s;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    end else begin
      e = model(s, x, y);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sel = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] x, y;
    logic [3:0]  s;

    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_res", {32'd0, res}, 64'd0);
    chk("reset_flags", {60'd0, flags}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd12, 32'h8000_0000, 32'd4);
    issue(4'd10, 32'h1234_5678, 32'd0);
    issue(4'd15, 32'hFFFF_0000, 32'h0000_FFFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
    end
    issue(4'd15, 32'hA5A5_1234, 32'hA5A5_1234);
    issue(4'd14, 32'd0, 32'd0);
    issue(4'd13, 32'hFFFF_FFFE, 32'd0);

    // Back-pressure: result must hold while the consumer stalls.
    drain();
    out_ready = 1'b0;
    issue(4'd2, 32'hFFFF_FFFF, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(4'd6, 32'hDEAD_BEEF, 32'h0F0F_F0F0);

    for (int i = 0; i < 8; i++) begin
      issue((i % 2 == 0) ? 4'd4 : 4'd5, $urandom, $urandom);
    end

    // Reset in the middle of a long shift discards it.
    drain();
    issue(4'd10, 32'd1, 32'd20);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_res", {32'd0, res}, 64'd0);
    chk("midreset_flags", {60'd0, flags}, 64'd0);
    q.delete();
    seen = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("postreset_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (30) @(posedge clk);
    #1;

    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      s = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      if ($urandom_range(0, 5) == 0) x = 32'h7FFF_FFFF;
      issue(s, x, y);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
